// File: rtl/bird_datapath.sv
// bird_datapath: per-frame erase / update / repaint of a 4x4 bird sprite.
//
// A frame_tick starts a redraw: the old sprite is erased, bird_y is moved
// according to the latched bird FSM mode, and the sprite is repainted at its
// new position. Also tracks the flap lift budget (rise_cnt) and reports it to
// the bird FSM through flag.
//
// Ports
//   clk, resetn       clock, synchronous active-low reset
//   state_in[2:0]     bird FSM state (010 START, 110 RAISING, 011 FALLING,
//                     001 STOP, 111 DRAW)
//   frame_tick        one-cycle frame strobe
//   key_press         one-cycle flap request
//   x[7:0], y[6:0]    pixel coordinate to plot
//   colour[2:0]       pixel colour
//   plot              pixel write enable
//   bird_y[6:0]       current sprite top row
//   flag              lift request back to the bird FSM
//   at_floor          bird_y is on the floor row (116)
//   draw_done         one-cycle pulse at the end of each redraw
//
// Sequencer states
//   state  | meaning
//   IDLE   | waiting for frame_tick
//   ERASE  | 16 cycles plotting the sprite in background colour at old bird_y
//   UPDATE | 1 cycle, apply motion for the latched mode
//   PAINT  | 16 cycles plotting the sprite at the new bird_y
//   DONE   | 1 cycle, draw_done pulse

module bird_datapath #(
   parameter int unsigned BIRD_X      = 40,
   parameter int unsigned START_Y     = 60,
   parameter int unsigned RISE_STEP   = 2,
   parameter int unsigned FALL_STEP   = 1,
   parameter int unsigned TOP_Y       = 8,
   parameter int unsigned RISE_FRAMES = 6
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] state_in,
   input  logic       frame_tick,
   input  logic       key_press,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic [6:0] bird_y,
   output logic       flag,
   output logic       at_floor,
   output logic       draw_done
);

   localparam logic [2:0] M_START   = 3'b010;
   localparam logic [2:0] M_RAISING = 3'b110;
   localparam logic [2:0] M_FALLING = 3'b011;
   localparam logic [2:0] M_STOP    = 3'b001;
   localparam logic [2:0] M_DRAW    = 3'b111;

   localparam logic [7:0] BIRD_X_W   = 8'(BIRD_X);
   localparam logic [6:0] START_Y_W  = 7'(START_Y);
   localparam logic [7:0] RISE_W     = 8'(RISE_STEP);
   localparam logic [7:0] FALL_W     = 8'(FALL_STEP);
   localparam logic [6:0] TOP_Y_W    = 7'(TOP_Y);
   localparam logic [2:0] RISE_FR_W  = 3'(RISE_FRAMES);
   localparam logic [6:0] FLOOR_Y    = 7'd116;
   localparam logic [7:0] FLOOR_Y_W  = 8'd116;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_UPDATE,
      S_PAINT,
      S_DONE
   } seq_t;

   seq_t       seq, seq_nxt;
   logic [3:0] cnt;
   logic [2:0] mode;
   logic [2:0] rise_cnt;
   logic [6:0] y_motion;
   logic [7:0] y_dec, y_inc;

   // state register
   always_ff @(posedge clk) begin
      if (!resetn) seq <= S_IDLE;
      else         seq <= seq_nxt;
   end

   // next-state logic; frame_tick outside IDLE is dropped, not queued
   always_comb begin
      seq_nxt = seq;
      case (seq)
         S_IDLE:   if (frame_tick) seq_nxt = S_ERASE;
         S_ERASE:  if (cnt == 4'd15) seq_nxt = S_UPDATE;
         S_UPDATE: seq_nxt = S_PAINT;
         S_PAINT:  if (cnt == 4'd15) seq_nxt = S_DONE;
         S_DONE:   seq_nxt = S_IDLE;
         default:  seq_nxt = S_IDLE;
      endcase
   end

   // output logic
   always_comb begin
      plot      = 1'b0;
      colour    = 3'b000;
      draw_done = 1'b0;
      case (seq)
         S_ERASE: plot = 1'b1;
         S_PAINT: begin
            plot   = 1'b1;
            colour = (mode == M_STOP) ? 3'b100 : 3'b110;
         end
         S_DONE:  draw_done = 1'b1;
         default: ;
      endcase
   end

   // row-major walk over the 4x4 sprite
   assign x = BIRD_X_W + {6'd0, cnt[1:0]};
   assign y = bird_y + {5'd0, cnt[3:2]};

   // 8-bit intermediates: bit 7 set after the subtract means it went below 0
   always_comb begin
      y_dec    = {1'b0, bird_y} - RISE_W;
      y_inc    = {1'b0, bird_y} + FALL_W;
      y_motion = bird_y;
      case (mode)
         M_START:   y_motion = START_Y_W;
         M_RAISING: y_motion = y_dec[7] ? 7'd0 : y_dec[6:0];
         M_FALLING: y_motion = (y_inc > FLOOR_Y_W) ? FLOOR_Y : y_inc[6:0];
         default:   y_motion = bird_y;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt      <= 4'd0;
         mode     <= M_START;
         bird_y   <= START_Y_W;
         rise_cnt <= 3'd0;
         flag     <= 1'b0;
         at_floor <= 1'b0;
      end else begin
         if (seq == S_ERASE || seq == S_PAINT) cnt <= cnt + 4'd1;
         else                                  cnt <= 4'd0;

         // DRAW is a transient bird-FSM state; keep the last motion mode
         if (state_in != M_DRAW) mode <= state_in;

         if (seq == S_UPDATE) bird_y <= y_motion;

         if (mode == M_STOP)
            rise_cnt <= 3'd0;
         else if (key_press)
            rise_cnt <= RISE_FR_W;
         else if (seq == S_UPDATE && mode == M_RAISING && rise_cnt != 3'd0)
            rise_cnt <= rise_cnt - 3'd1;

         flag     <= (rise_cnt != 3'd0) && (bird_y > TOP_Y_W);
         at_floor <= (bird_y == FLOOR_Y);
      end
   end

endmodule

// File: tb/tb_bird_datapath.sv
`timescale 1ns/1ps
module tb_bird_datapath;

   logic       clk = 1'b0;
   logic       resetn;
   logic [2:0] state_in;
   logic       frame_tick;
   logic       key_press;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic [6:0] bird_y;
   logic       flag;
   logic       at_floor;
   logic       draw_done;

   bird_datapath dut (
      .clk(clk), .resetn(resetn), .state_in(state_in), .frame_tick(frame_tick),
      .key_press(key_press), .x(x), .y(y), .colour(colour), .plot(plot),
      .bird_y(bird_y), .flag(flag), .at_floor(at_floor), .draw_done(draw_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_done;
      int c;
      int px;
      int py;
      int col;
   } item_t;

   item_t sb[$];
   item_t mon_it;
   int    errors = 0;
   int    checks = 0;
   int    model_y = 60;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   // scoreboard monitor: every plot / draw_done must match the queue head
   always @(negedge clk) begin
      if (resetn === 1'b1 && (plot === 1'b1 || draw_done === 1'b1)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: plot=%0d done=%0d x=%0d y=%0d at cyc %0d, required no output",
                     plot, draw_done, x, y, cyc);
         end else begin
            mon_it = sb.pop_front();
            if (draw_done === 1'b1) begin
               if (!mon_it.is_done || mon_it.c != cyc || int'(bird_y) != mon_it.py || plot !== 1'b0) begin
                  errors++;
                  $display("FAIL done: got done cyc=%0d bird_y=%0d plot=%0d, required is_done=%0d cyc=%0d bird_y=%0d",
                           cyc, bird_y, plot, mon_it.is_done, mon_it.c, mon_it.py);
               end
            end else begin
               if (mon_it.is_done || mon_it.c != cyc || int'(x) != mon_it.px ||
                   int'(y) != mon_it.py || int'(colour) != mon_it.col) begin
                  errors++;
                  $display("FAIL pixel: got cyc=%0d x=%0d y=%0d col=%0d, required is_done=%0d cyc=%0d x=%0d y=%0d col=%0d",
                           cyc, x, y, colour, mon_it.is_done, mon_it.c, mon_it.px, mon_it.py, mon_it.col);
               end
            end
         end
      end
   end

   task automatic push_item(input bit d, input int c, input int px, input int py, input int col);
      item_t e;
      e.is_done = d; e.c = c; e.px = px; e.py = py; e.col = col;
      sb.push_back(e);
   endtask

   task automatic tick_cycle();
      @(posedge clk); #1;
   endtask

   task automatic set_mode(input logic [2:0] m);
      tick_cycle();
      state_in = m;
   endtask

   // one full redraw; m is the mode the DUT is expected to act on
   task automatic run_frame(input logic [2:0] m, input bit extra);
      int t, oy, ny, col;
      oy = model_y;
      case (m)
         3'b010:  ny = 60;
         3'b110:  ny = (oy - 2 < 0) ? 0 : oy - 2;
         3'b011:  ny = (oy + 1 > 116) ? 116 : oy + 1;
         default: ny = oy;
      endcase
      col = (m == 3'b001) ? 4 : 6;
      tick_cycle();
      t = cyc;
      for (int i = 0; i < 16; i++) push_item(1'b0, t + 1 + i, 40 + i % 4, oy + i / 4, 0);
      for (int i = 0; i < 16; i++) push_item(1'b0, t + 18 + i, 40 + i % 4, ny + i / 4, col);
      push_item(1'b1, t + 34, 0, ny, 0);
      frame_tick = 1'b1;
      tick_cycle();
      frame_tick = 1'b0;
      if (extra) begin
         repeat (4) tick_cycle();
         frame_tick = 1'b1;
         tick_cycle();
         frame_tick = 1'b0;
      end
      while (cyc < t + 36) tick_cycle();
      model_y = ny;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      resetn = 1'b0; state_in = 3'b010; frame_tick = 1'b0; key_press = 1'b0;
      repeat (3) tick_cycle();
      check("rst_x", x, 40);
      check("rst_y", y, 60);
      check("rst_colour", colour, 0);
      check("rst_plot", plot, 0);
      check("rst_done", draw_done, 0);
      check("rst_flag", flag, 0);
      check("rst_at_floor", at_floor, 0);
      check("rst_bird_y", bird_y, 60);
      resetn = 1'b1;
      tick_cycle();

      // START frame, then a frame with a stray tick during ERASE
      run_frame(3'b010, 1'b0);
      check("start_bird_y", bird_y, 60);
      run_frame(3'b010, 1'b1);
      repeat (40) tick_cycle();
      check("extra_tick_drained", sb.size(), 0);

      // flap: lift granted for 6 frames
      tick_cycle();
      state_in = 3'b110; key_press = 1'b1;
      tick_cycle();
      key_press = 1'b0;
      tick_cycle();
      check("flag_after_key", flag, 1);
      for (int i = 0; i < 6; i++) begin
         run_frame(3'b110, 1'b0);
         if (i == 4) check("flag_5th_frame", flag, 1);
      end
      check("rise_bird_y", bird_y, 48);
      check("flag_exhausted", flag, 0);

      // reset in the middle of ERASE
      tick_cycle();
      t = cyc;
      for (int i = 0; i < 4; i++) push_item(1'b0, t + 1 + i, 40 + i, 48, 0);
      frame_tick = 1'b1;
      tick_cycle();
      frame_tick = 1'b0;
      repeat (4) tick_cycle();
      resetn = 1'b0;
      tick_cycle();
      check("abort_plot", plot, 0);
      check("abort_bird_y", bird_y, 60);
      resetn = 1'b1;
      model_y = 60;
      repeat (6) tick_cycle();
      check("abort_drained", sb.size(), 0);

      // rise to the top, step down one row, then clamp at 0
      for (int i = 0; i < 30; i++) run_frame(3'b110, 1'b0);
      check("top_exact_0", bird_y, 0);
      set_mode(3'b011);
      run_frame(3'b011, 1'b0);
      check("fall_to_1", bird_y, 1);
      set_mode(3'b110);
      run_frame(3'b110, 1'b0);
      check("clamp_0", bird_y, 0);

      // fall to the floor
      set_mode(3'b011);
      for (int i = 0; i < 115; i++) run_frame(3'b011, 1'b0);
      check("y_115", bird_y, 115);
      check("at_floor_115", at_floor, 0);
      run_frame(3'b011, 1'b0);
      check("y_116", bird_y, 116);
      run_frame(3'b011, 1'b0);
      check("y_116_held", bird_y, 116);
      check("at_floor_116", at_floor, 1);

      // STOP clears lift and ignores flaps
      key_press = 1'b1;
      tick_cycle();
      key_press = 1'b0;
      tick_cycle();
      check("flag_falling_key", flag, 1);
      state_in = 3'b001;
      repeat (3) tick_cycle();
      check("flag_stop_clear", flag, 0);
      key_press = 1'b1;
      tick_cycle();
      key_press = 1'b0;
      repeat (3) tick_cycle();
      check("flag_stop_key", flag, 0);
      run_frame(3'b001, 1'b0);
      check("stop_bird_y", bird_y, 116);
      set_mode(3'b111);
      run_frame(3'b001, 1'b0);
      check("draw_hold_bird_y", bird_y, 116);
      check("final_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bird_datapath.md
BIRD_DATAPATH -- requirements
Module: bird_datapath

Interface
REQ-001 Parameter BIRD_X, default 40, fixed sprite left column (0..156).
REQ-002 Parameter START_Y, default 60, sprite top row after START.
REQ-003 Parameter RISE_STEP, default 2, rows moved up per frame while raising.
REQ-004 Parameter FALL_STEP, default 1, rows moved down per frame while falling.
REQ-005 Parameter TOP_Y, default 8, minimum row at which rising is still permitted.
REQ-006 Parameter RISE_FRAMES, default 6, frames of lift granted per key press.
REQ-007 clk  in  1  system clock; reset resetn, synchronous, active-low.
REQ-008 resetn  in  1  synchronous active-low reset.
REQ-009 state_in  in  3  bird FSM state: 010 START, 110 RAISING, 011 FALLING, 001 STOP, 111 DRAW.
REQ-010 frame_tick  in  1  one-cycle frame strobe.
REQ-011 key_press  in  1  one-cycle flap request.
REQ-012 x  out  8  pixel column to plot; y  out  7  pixel row to plot; colour  out  3  pixel colour.
REQ-013 plot  out  1  pixel write enable.
REQ-014 bird_y  out  7  current sprite top row.
REQ-015 flag  out  1  lift request to bird FSM (1 = keep/start raising).
REQ-016 at_floor  out  1  high when bird_y == 116.
REQ-017 draw_done  out  1  one-cycle pulse at end of each frame redraw.

Function
REQ-018 Block SHALL latch mode <= state_in every cycle state_in != 111; while state_in == 111, mode holds.
REQ-019 Sequencer states SHALL be IDLE, ERASE, UPDATE, PAINT, DONE.
REQ-020 IDLE -> ERASE on frame_tick; frame_tick in any other state SHALL be ignored (no queuing).
REQ-021 ERASE and PAINT SHALL each last exactly 16 cycles using 4-bit counter cnt; x = BIRD_X + cnt[1:0], y = bird_y + cnt[3:2] (row-major); plot = 1 only in ERASE/PAINT.
REQ-022 ERASE colour SHALL be 000; PAINT colour SHALL be 110, or 100 when mode == STOP.
REQ-023 UPDATE SHALL last one cycle, plot = 0, applying motion per mode: START -> bird_y = START_Y; RAISING -> bird_y = max(bird_y - RISE_STEP, 0); FALLING -> bird_y = min(bird_y + FALL_STEP, 116); STOP -> unchanged.
REQ-024 Arithmetic SHALL use 8-bit intermediates so subtraction underflow clamps to 0, never wraps.
REQ-025 DONE SHALL last one cycle with draw_done = 1, then IDLE.
REQ-026 Latency: frame_tick at cycle t -> ERASE t+1..t+16, UPDATE t+17, PAINT t+18..t+33, draw_done at t+34, IDLE at t+35.
REQ-027 rise_cnt (3-bit) SHALL load RISE_FRAMES on key_press unless mode == STOP; SHALL decrement at UPDATE when nonzero and mode == RAISING; key_press in UPDATE cycle: load wins.
REQ-028 mode == STOP SHALL clear rise_cnt and ignore key_press.
REQ-029 flag SHALL be registered: flag = (rise_cnt != 0) && (bird_y > TOP_Y), updated every cycle.
REQ-030 at_floor SHALL be registered from bird_y.

Reset
REQ-031 resetn = 0 at a rising edge SHALL force: sequencer IDLE, cnt 0, bird_y = START_Y, rise_cnt 0, mode START, plot 0, draw_done 0, flag 0, at_floor 0, x = BIRD_X, y = START_Y, colour 000.
REQ-032 Reset mid-ERASE/PAINT SHALL abort the sequence with plot = 0 on the next cycle; no partial update of bird_y.

Verification
REQ-033 Reset, state_in = 010, frame_tick -> 16 plots colour 000 at (40..43, 60..63), then 16 plots colour 110 at same pixels, draw_done at t+34.
REQ-034 bird_y = 1, mode RAISING, frame_tick -> bird_y = 0 after UPDATE (clamp), PAINT rows 0..3.
REQ-035 bird_y = 115, mode FALLING, two frames -> bird_y 116 then 116, at_floor = 1.
REQ-036 key_press with bird_y = 60 -> flag = 1 within 2 cycles; 6 RAISING frames -> bird_y = 48, flag = 0.
REQ-037 frame_tick pulsed at t+5 during ERASE -> ignored, exactly one draw_done per sequence.
REQ-038 state_in = 001, key_press, frame_tick -> rise_cnt 0, flag 0, bird_y unchanged, PAINT colour 100.
